// File: rtl/leaf_pkg.sv
// Shared types and default sizing for the leaf memory datapath.
package leaf_pkg;

   localparam int DATA_WIDTH = 11;
   localparam int PATCH_SIZE = 5;
   localparam int LEAF_SIZE  = 8;
   localparam int NUM_LEAVES = 64;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEARCH,
      DRAIN
   } arb_state_t;

   typedef logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] leaf_t;

endpackage

// File: rtl/leaf_mem_arbiter.sv
// Arbiter for port 0 of the leaf SRAM: the leaf loader streams writes to
// addresses 0..NUM_LEAVES-1, the search controller issues reads that always win.
// Optional build macro LEAF_ARB_STALL_CNT_EN adds a loader stall counter output.
module leaf_mem_arbiter
   import leaf_pkg::*;
#(
   parameter int DATA_WIDTH = leaf_pkg::DATA_WIDTH,
   parameter int PATCH_SIZE = leaf_pkg::PATCH_SIZE,
   parameter int LEAF_SIZE  = leaf_pkg::LEAF_SIZE,
   parameter int NUM_LEAVES = leaf_pkg::NUM_LEAVES,
   parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 ld_valid,
   input  logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] ld_wleaf,
   output logic                                                 ld_ready,
   input  logic                                                 fsm_start,
   input  logic                                                 fsm_done,
   input  logic                                                 fsm_csb0,
   input  logic [ADDR_WIDTH-1:0]                                fsm_addr0,
   output logic                                                 fsm_rvalid,
   output logic                                                 mem_csb0,
   output logic                                                 mem_web0,
   output logic [ADDR_WIDTH-1:0]                                mem_addr0,
   output logic [LEAF_SIZE-1:0][PATCH_SIZE-1:0][DATA_WIDTH-1:0] mem_wleaf0,
   output logic                                                 leaves_loaded,
   output logic                                                 load_done,
   output logic                                                 busy,
   output logic                                                 err_start_unloaded
`ifdef LEAF_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                                          ld_stall_cnt
`endif
);

   arb_state_t            state_q;
   arb_state_t            state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic                  leaves_loaded_q;
   logic                  err_q;
   logic                  rvalid_q;
   logic                  read_grant;
   logic                  write_grant;
   logic                  last_beat;

   // Grant decode: a search read always owns the port, loader only in LOAD.
   always_comb begin
      read_grant  = ~fsm_csb0;
      write_grant = (state_q == LOAD) & ld_valid & fsm_csb0;
      last_beat   = (wr_ptr_q == ADDR_WIDTH'(NUM_LEAVES - 1));
   end

   // Next-state logic; a start request outranks a pending loader in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fsm_start) begin
               if (leaves_loaded_q) begin
                  state_d = SEARCH;
               end
            end else if (ld_valid) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (write_grant && last_beat) begin
               state_d = IDLE;
            end
         end
         SEARCH: begin
            if (fsm_done) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM port mux and handshake outputs; undriven port fields park at zero.
   always_comb begin
      mem_csb0   = 1'b1;
      mem_web0   = 1'b1;
      mem_addr0  = '0;
      mem_wleaf0 = '0;
      if (read_grant) begin
         mem_csb0  = 1'b0;
         mem_addr0 = fsm_addr0;
      end else if (write_grant) begin
         mem_csb0   = 1'b0;
         mem_web0   = 1'b0;
         mem_addr0  = wr_ptr_q;
         mem_wleaf0 = ld_wleaf;
      end
      ld_ready           = write_grant;
      load_done          = write_grant & last_beat;
      busy               = (state_q != IDLE);
      leaves_loaded      = leaves_loaded_q;
      err_start_unloaded = err_q;
      fsm_rvalid         = rvalid_q;
   end

   // State, write pointer, sticky flags and the one-cycle read-valid delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         wr_ptr_q        <= '0;
         leaves_loaded_q <= 1'b0;
         err_q           <= 1'b0;
         rvalid_q        <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= read_grant;
         if (write_grant) begin
            wr_ptr_q        <= last_beat ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
            leaves_loaded_q <= last_beat;
         end
         if ((state_q == IDLE) && fsm_start && !leaves_loaded_q) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef LEAF_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Count loader cycles lost to search reads, restarting with each new load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if ((state_q == IDLE) && (state_d == LOAD)) begin
         stall_cnt_q <= '0;
      end else if ((state_q == LOAD) && ld_valid && !write_grant && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign ld_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_leaf_mem_arbiter.sv
// Scoreboard bench for leaf_mem_arbiter: the stimulus process runs a
// transaction-level model of the loader/search protocol and queues the
// expected port activity per cycle; an independent monitor compares.
module tb_leaf_mem_arbiter;
   import leaf_pkg::*;

   localparam int AW = $clog2(NUM_LEAVES);
   localparam int LW = LEAF_SIZE * PATCH_SIZE * DATA_WIDTH;

   localparam int M_IDLE   = 0;
   localparam int M_LOAD   = 1;
   localparam int M_SEARCH = 2;
   localparam int M_DRAIN  = 3;

   typedef struct {
      logic          ready;
      logic          done;
      logic          busy;
      logic          loaded;
      logic          err;
      logic          rvalid;
      logic          csb;
      logic          web;
      logic [AW-1:0] addr;
      leaf_t         data;
      logic          chkData;
      int            stall;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          ld_valid;
   leaf_t         ld_wleaf;
   logic          ld_ready;
   logic          fsm_start;
   logic          fsm_done;
   logic          fsm_csb0;
   logic [AW-1:0] fsm_addr0;
   logic          fsm_rvalid;
   logic          mem_csb0;
   logic          mem_web0;
   logic [AW-1:0] mem_addr0;
   leaf_t         mem_wleaf0;
   logic          leaves_loaded;
   logic          load_done;
   logic          busy;
   logic          err_start_unloaded;
`ifdef LEAF_ARB_STALL_CNT_EN
   logic [15:0]   ld_stall_cnt;
`endif

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // model of the protocol as seen from outside the block
   int    mMode;
   int    mWrites;
   bit    mLoaded;
   bit    mErr;
   bit    mRvalid;
   int    mStall;
   int    mLoadsDone;
   leaf_t curLeaf;

   leaf_mem_arbiter dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .ld_valid           (ld_valid),
      .ld_wleaf           (ld_wleaf),
      .ld_ready           (ld_ready),
      .fsm_start          (fsm_start),
      .fsm_done           (fsm_done),
      .fsm_csb0           (fsm_csb0),
      .fsm_addr0          (fsm_addr0),
      .fsm_rvalid         (fsm_rvalid),
      .mem_csb0           (mem_csb0),
      .mem_web0           (mem_web0),
      .mem_addr0          (mem_addr0),
      .mem_wleaf0         (mem_wleaf0),
      .leaves_loaded      (leaves_loaded),
      .load_done          (load_done),
      .busy               (busy),
      .err_start_unloaded (err_start_unloaded)
`ifdef LEAF_ARB_STALL_CNT_EN
      ,
      .ld_stall_cnt       (ld_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic leaf_t randLeaf();
      leaf_t l;
      for (int i = 0; i < LEAF_SIZE; i++) begin
         for (int j = 0; j < PATCH_SIZE; j++) begin
            l[i][j] = DATA_WIDTH'($urandom);
         end
      end
      return l;
   endfunction

   task automatic modelReset();
      mMode   = M_IDLE;
      mWrites = 0;
      mLoaded = 0;
      mErr    = 0;
      mRvalid = 0;
      mStall  = 0;
   endtask

   // One clock of stimulus: drive, queue the expected response, advance the model.
   task automatic applyStimulus(input bit v, input bit s, input bit d, input bit c, input logic [AW-1:0] a);
      exp_t e;
      bit   accepted;
      @(posedge clk);
      #1;
      ld_valid  = v;
      fsm_start = s;
      fsm_done  = d;
      fsm_csb0  = c;
      fsm_addr0 = a;
      ld_wleaf  = curLeaf;
      accepted  = (mMode == M_LOAD) && v && c;
      e.ready   = accepted;
      e.done    = accepted && (mWrites == NUM_LEAVES - 1);
      e.busy    = (mMode != M_IDLE);
      e.loaded  = mLoaded;
      e.err     = mErr;
      e.rvalid  = mRvalid;
      e.stall   = mStall;
      if (!c) begin
         e.csb = 0; e.web = 1; e.addr = a; e.data = '0; e.chkData = 0;
      end else if (accepted) begin
         e.csb = 0; e.web = 0; e.addr = AW'(mWrites); e.data = curLeaf; e.chkData = 1;
      end else begin
         e.csb = 1; e.web = 1; e.addr = '0; e.data = '0; e.chkData = 1;
      end
      expQ.push_back(e);
      mRvalid = !c;
      case (mMode)
         M_IDLE: begin
            if (s) begin
               if (mLoaded) mMode = M_SEARCH;
               else mErr = 1;
            end else if (v) begin
               mMode  = M_LOAD;
               mStall = 0;
            end
         end
         M_LOAD: begin
            if (accepted) begin
               curLeaf = randLeaf();
               if (mWrites == NUM_LEAVES - 1) begin
                  mWrites = 0;
                  mLoaded = 1;
                  mMode   = M_IDLE;
                  mLoadsDone++;
               end else begin
                  mWrites++;
                  mLoaded = 0;
               end
            end else if (v && mStall < 65535) begin
               mStall++;
            end
         end
         M_SEARCH: if (d) mMode = M_DRAIN;
         default:  mMode = M_IDLE;
      endcase
   endtask

   // Stream a full leaf set, stealing the port for reads at two chosen addresses.
   task automatic runLoad(input int at1, input int n1, input int at2, input int n2, input bit randReads);
      int target;
      int left1;
      int left2;
      bit c;
      target = mLoadsDone + 1;
      left1  = n1;
      left2  = n2;
      for (int i = 0; i < 600 && mLoadsDone < target; i++) begin
         c = 1;
         if (mMode == M_LOAD && mWrites == at1 && left1 > 0) begin
            c = 0; left1--;
         end else if (mMode == M_LOAD && mWrites == at2 && left2 > 0) begin
            c = 0; left2--;
         end else if (randReads && ($urandom % 4 == 0)) begin
            c = 0;
         end
         applyStimulus(1, 0, 1, c, c ? AW'(0) : (mWrites == at1 ? AW'(5) : AW'($urandom)));
      end
      if (mLoadsDone < target) begin
         errors++;
         $display("[TB] FAIL load_timeout: actual=%0d beats required=%0d", mWrites, NUM_LEAVES);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_ld_ready", ld_ready, 0);
      checkOutput("rst_mem_csb0", mem_csb0, 1);
      checkOutput("rst_mem_web0", mem_web0, 1);
      checkOutput("rst_mem_addr0", mem_addr0, 0);
      checkOutput("rst_mem_wleaf0", mem_wleaf0, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_load_done", load_done, 0);
      checkOutput("rst_leaves_loaded", leaves_loaded, 0);
      checkOutput("rst_err", err_start_unloaded, 0);
      checkOutput("rst_fsm_rvalid", fsm_rvalid, 0);
`ifdef LEAF_ARB_STALL_CNT_EN
      checkOutput("rst_stall_cnt", ld_stall_cnt, 0);
`endif
   endtask

   // Monitor: every live cycle consume one expectation and compare all outputs.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("ld_ready", ld_ready, e.ready);
         checkOutput("load_done", load_done, e.done);
         checkOutput("busy", busy, e.busy);
         checkOutput("leaves_loaded", leaves_loaded, e.loaded);
         checkOutput("err_start_unloaded", err_start_unloaded, e.err);
         checkOutput("fsm_rvalid", fsm_rvalid, e.rvalid);
         checkOutput("mem_csb0", mem_csb0, e.csb);
         checkOutput("mem_web0", mem_web0, e.web);
         checkOutput("mem_addr0", mem_addr0, e.addr);
         if (e.chkData) checkOutput("mem_wleaf0", mem_wleaf0, e.data);
`ifdef LEAF_ARB_STALL_CNT_EN
         checkOutput("ld_stall_cnt", ld_stall_cnt, LW'(e.stall));
`endif
      end
   end

   initial begin
      rst_n      = 0;
      ld_valid   = 0;
      fsm_start  = 0;
      fsm_done   = 0;
      fsm_csb0   = 1;
      fsm_addr0  = '0;
      mLoadsDone = 0;
      curLeaf    = randLeaf();
      ld_wleaf   = curLeaf;
      modelReset();
      #12;
      checkResetValues();
      #10;
      rst_n = 1;

      $display("[TB] start while unloaded");
      applyStimulus(0, 1, 0, 1, '0);
      applyStimulus(0, 0, 0, 1, '0);
      applyStimulus(1, 1, 0, 1, '0);
      applyStimulus(0, 0, 0, 1, '0);

      $display("[TB] full load with collisions");
      runLoad(10, 3, 40, 4, 0);
      applyStimulus(0, 0, 0, 1, '0);
      applyStimulus(0, 0, 0, 0, AW'(17));

      $display("[TB] search isolation");
      applyStimulus(1, 1, 0, 1, '0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0, 0, ($urandom % 3 != 0), AW'($urandom));
      end
      applyStimulus(1, 0, 1, 0, AW'(33));
      for (int i = 0; i < 200 && !(mMode == M_LOAD && mWrites == 30); i++) begin
         applyStimulus(1, 0, 0, 1, '0);
      end

      $display("[TB] reset mid-load");
      @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      checkResetValues();
      ld_valid = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      runLoad(12, 2, 50, 5, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom % 10) < 7, ($urandom % 40) == 0, ($urandom % 20) == 0,
                       ($urandom % 5) != 0, AW'($urandom));
      end
      runLoad(-1, 0, -1, 0, 1);
      applyStimulus(0, 1, 0, 1, '0);
      applyStimulus(0, 0, 1, 0, AW'(63));
      applyStimulus(0, 0, 0, 1, '0);
      applyStimulus(0, 0, 0, 1, '0);
      @(posedge clk);
      #6;
      checkOutput("queue_drained", LW'(expQ.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
